// File: rtl/aes_key_expand.sv
// AES-128 key-schedule engine: emits round keys 0..NR in order over a valid/ready handshake.
// Optional KEY_EXP_STORE_EN adds an 11-entry round-key store with a registered read port.

module sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0 naturally)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign out_o = affine(gf_inv(in_i));

endmodule

module aes_key_expand #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [127:0]     key,
    input  logic             flush,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [127:0]     round_key,
    output logic [IDX_W-1:0] round_idx,
    output logic             done
`ifdef KEY_EXP_STORE_EN
    ,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [127:0]     rd_key,
    output logic             store_full
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] ONE_IDX  = {{(IDX_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [127:0]       key_q, key_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         rcon_q, rcon_d;
    logic               done_q, done_d;

    logic [31:0]        rot_s;
    logic [31:0]        sub_s;
    logic [31:0]        t_s;
    logic [31:0]        w0_s, w1_s, w2_s, w3_s;
    logic [127:0]       next_key_s;
    logic               accept_s;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    assign rot_s = {key_q[23:0], key_q[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sbox u_sbox (
            .in_i  (rot_s[8*b +: 8]),
            .out_o (sub_s[8*b +: 8])
        );
    end

    assign t_s        = sub_s ^ {rcon_q, 24'h000000};
    assign w0_s       = key_q[127:96] ^ t_s;
    assign w1_s       = key_q[95:64]  ^ w0_s;
    assign w2_s       = key_q[63:32]  ^ w1_s;
    assign w3_s       = key_q[31:0]   ^ w2_s;
    assign next_key_s = {w0_s, w1_s, w2_s, w3_s};

    assign accept_s = (state_q == ST_EMIT) && rk_ready && !flush;

    // Next-state logic: flush overrides everything, including a pending accept
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            idx_d   = ZERO_IDX;
            rcon_d  = 8'h01;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_EMIT;
                        key_d   = key;
                        idx_d   = ZERO_IDX;
                        rcon_d  = 8'h01;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    if (rk_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            key_d  = next_key_s;
                            idx_d  = idx_q + ONE_IDX;
                            rcon_d = xtime(rcon_q);
                        end
                    end else begin
                        state_d = ST_EMIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and key registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= 128'h0;
            idx_q   <= ZERO_IDX;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign rk_valid  = (state_q == ST_EMIT);
    assign round_key = key_q;
    assign round_idx = idx_q;
    assign done      = done_q;

`ifdef KEY_EXP_STORE_EN
    logic [127:0] store_q [0:NR];
    logic [127:0] rd_key_q;
    logic         full_q, full_d;

    // Full flag: cleared by flush or an accepted start, set when the last key lands
    always_comb begin
        full_d = full_q;
        if (flush || ((state_q == ST_IDLE) && start)) begin
            full_d = 1'b0;
        end else if (accept_s && (idx_q == LAST_IDX)) begin
            full_d = 1'b1;
        end else begin
            full_d = full_q;
        end
    end

    // Key store and registered read port; contents survive flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                store_q[i] <= 128'h0;
            end
            rd_key_q <= 128'h0;
            full_q   <= 1'b0;
        end else begin
            if (accept_s) begin
                store_q[idx_q] <= key_q;
            end
            rd_key_q <= (rd_idx <= LAST_IDX) ? store_q[rd_idx] : 128'h0;
            full_q   <= full_d;
        end
    end

    assign rd_key     = rd_key_q;
    assign store_full = full_q;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a word-array key-schedule model.
`timescale 1ns/1ps
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic         rk_ready = 1'b0;
    logic [127:0] key = 128'h0;
    logic         busy, rk_valid, done;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
`ifdef KEY_EXP_STORE_EN
    logic [3:0]   rd_idx = 4'd0;
    logic [127:0] rd_key;
    logic         store_full;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_t [0:255];
    logic [127:0] exp_k  [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_key_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .flush     (flush),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .done      (done)
`ifdef KEY_EXP_STORE_EN
        ,
        .rd_idx    (rd_idx),
        .rd_key    (rd_key),
        .store_full(store_full)
`endif
    );

    always #5 clk = ~clk;

    // GF(2^8) product by polynomial multiply then long-division reduction
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_t[x] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [7:0]  rc [0:9];
        logic [31:0] tmp;
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp = tmp ^ {rc[i/4-1], 24'h0};
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Pulse start for one cycle; returns at the negedge where idx 0 is visible
    task automatic do_start(input logic [127:0] k);
        @(negedge clk);
        key = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, rk_valid, done, round_idx, round_key} !== 135'h0) begin
            errors++;
            $display("FAIL reset_hold: got busy=%b valid=%b done=%b idx=%0d key=%h want all zero", busy, rk_valid, done, round_idx, round_key);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, rk_valid, done, round_idx, round_key} !== 135'h0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b valid=%b done=%b idx=%0d key=%h want all zero", busy, rk_valid, done, round_idx, round_key);
        end
`ifdef KEY_EXP_STORE_EN
        checks++;
        if ({store_full, rd_key} !== 129'h0) begin
            errors++;
            $display("FAIL reset_store: got full=%b rd_key=%h want 0", store_full, rd_key);
        end
`endif
    endtask

    task automatic test_known_answer(input logic [127:0] k, input logic [127:0] e1, input logic [127:0] e10);
        model_expand(k);
        rk_ready = 1'b1;
        do_start(k);
        for (int i = 0; i <= 10; i++) begin
            checks++;
            if (rk_valid !== 1'b1 || done !== 1'b0 || round_idx !== 4'(i) || round_key !== exp_k[i]) begin
                errors++;
                $display("FAIL ka_stream: got valid=%b done=%b idx=%0d key=%h want 1 0 %0d %h", rk_valid, done, round_idx, round_key, i, exp_k[i]);
            end
            if (i == 1) begin
                checks++;
                if (round_key !== e1) begin
                    errors++;
                    $display("FAIL ka_idx1: got %h want %h", round_key, e1);
                end
            end
            if (i == 10) begin
                checks++;
                if (round_key !== e10) begin
                    errors++;
                    $display("FAIL ka_idx10: got %h want %h", round_key, e10);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ka_done: got done=%b valid=%b busy=%b want 1 0 0", done, rk_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL ka_done_once: got done=%b want 0", done);
        end
        rk_ready = 1'b0;
    endtask

    task automatic test_backpressure(input logic [127:0] k);
        int exp_i;
        int cyc;
        model_expand(k);
        rk_ready = 1'b0;
        do_start(k);
        exp_i = 0;
        for (cyc = 0; cyc < 400 && exp_i < 11; cyc++) begin
            checks++;
            if (rk_valid !== 1'b1 || round_idx !== 4'(exp_i) || round_key !== exp_k[exp_i]) begin
                errors++;
                $display("FAIL bp_stream: got valid=%b idx=%0d key=%h want 1 %0d %h", rk_valid, round_idx, round_key, exp_i, exp_k[exp_i]);
            end
            rk_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rk_ready) exp_i++;
        end
        rk_ready = 1'b0;
        checks++;
        if (exp_i < 11 || done !== 1'b1 || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: got keys=%0d done=%b valid=%b want 11 1 0", exp_i, done, rk_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_start_busy_flush();
        logic [127:0] k2, k3;
        model_expand(FIPS_KEY);
        rk_ready = 1'b1;
        do_start(FIPS_KEY);
        for (int i = 0; i <= 6; i++) begin
            checks++;
            if (round_idx !== 4'(i) || round_key !== exp_k[i]) begin
                errors++;
                $display("FAIL sbf_stream: got idx=%0d key=%h want %0d %h", round_idx, round_key, i, exp_k[i]);
            end
            start = (i == 4);
            key   = ~FIPS_KEY;
            flush = (i == 6);
            @(negedge clk);
        end
        start = 1'b0;
        flush = 1'b0;
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || round_idx !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL sbf_flush: got valid=%b busy=%b idx=%0d done=%b want 0 0 0 0", rk_valid, busy, round_idx, done);
        end
        flush = 1'b1;
        start = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL sbf_flush_start: got busy=%b want 0", busy);
        end
        k2 = {$urandom, $urandom, $urandom, $urandom};
        model_expand(k2);
        do_start(k2);
        for (int i = 0; i <= 10; i++) begin
            checks++;
            if (round_idx !== 4'(i) || round_key !== exp_k[i]) begin
                errors++;
                $display("FAIL sbf_restart: got idx=%0d key=%h want %0d %h", round_idx, round_key, i, exp_k[i]);
            end
            @(negedge clk);
        end
        k3 = {$urandom, $urandom, $urandom, $urandom};
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL sbf_done: got %b want 1", done);
        end
        start = 1'b1;
        key = k3;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rk_valid !== 1'b1 || round_idx !== 4'd0 || round_key !== k3) begin
            errors++;
            $display("FAIL sbf_start_on_done: got busy=%b valid=%b idx=%0d key=%h want 1 1 0 %h", busy, rk_valid, round_idx, round_key, k3);
        end
        rk_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        rk_ready = 1'b1;
        do_start(FIPS_KEY);
        repeat (7) @(negedge clk);
        checks++;
        if (round_idx !== 4'd7) begin
            errors++;
            $display("FAIL rm_reach7: got idx=%0d want 7", round_idx);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, rk_valid, done, round_idx, round_key} !== 135'h0) begin
            errors++;
            $display("FAIL rm_async: got busy=%b valid=%b done=%b idx=%0d key=%h want all zero", busy, rk_valid, done, round_idx, round_key);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_start(128'h0);
        @(negedge clk);
        checks++;
        if (round_idx !== 4'd1 || round_key !== 128'h62636363626363636263636362636363) begin
            errors++;
            $display("FAIL rm_zero_idx1: got idx=%0d key=%h want 1 62636363626363636263636362636363", round_idx, round_key);
        end
        rk_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

`ifdef KEY_EXP_STORE_EN
    task automatic test_store();
        int cyc;
        model_expand(FIPS_KEY);
        rk_ready = 1'b1;
        do_start(FIPS_KEY);
        for (cyc = 0; cyc < 30 && done !== 1'b1; cyc++) @(negedge clk);
        rk_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || store_full !== 1'b1) begin
            errors++;
            $display("FAIL st_full: got done=%b full=%b want 1 1", done, store_full);
        end
        rd_idx = 4'd10;
        @(negedge clk);
        checks++;
        if (rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL st_rd10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rd_key);
        end
        rd_idx = 4'd12;
        @(negedge clk);
        checks++;
        if (rd_key !== 128'h0) begin
            errors++;
            $display("FAIL st_rd12: got %h want 0", rd_key);
        end
        for (int i = 10; i >= 0; i--) begin
            rd_idx = 4'(i);
            @(negedge clk);
            checks++;
            if (rd_key !== exp_k[i]) begin
                errors++;
                $display("FAIL st_reverse: idx %0d got %h want %h", i, rd_key, exp_k[i]);
            end
        end
        flush = 1'b1;
        rd_idx = 4'd10;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (store_full !== 1'b0 || rd_key !== exp_k[10]) begin
            errors++;
            $display("FAIL st_flush: got full=%b rd_key=%h want 0 %h", store_full, rd_key, exp_k[10]);
        end
    endtask
`endif

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        test_reset();
        test_known_answer(FIPS_KEY, 128'ha0fafe1788542cb123a339392a6c7605, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        test_known_answer(128'h0, 128'h62636363626363636263636362636363, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        test_backpressure(FIPS_KEY);
        for (int n = 0; n < 4; n++) test_backpressure({$urandom, $urandom, $urandom, $urandom});
        test_start_busy_flush();
        test_reset_mid();
`ifdef KEY_EXP_STORE_EN
        test_store();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Sequential AES-128 key-schedule engine that produces round keys 0..10 in order, one per accepted handshake.
- Applies SubWord through four instances of the team's byte substitution block (sbox), all driven from the last word of the current key.
- Sits beside the round datapath and supplies round_key to the AddRoundKey stage through a valid/ready handshake.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported, other values are illegal.
- IDX_W, 4, width of round_idx.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request expansion of key; sampled only in IDLE.
- key  input  128  cipher key; word w0 = key[127:96], w3 = key[31:0].
- flush  input  1  synchronous abort.
- busy  output  1  high whenever state is not IDLE.
- rk_valid  output  1  round_key and round_idx are valid.
- rk_ready  input  1  consumer accepts the current round key.
- round_key  output  128  current round key.
- round_idx  output  IDX_W  index of round_key, 0..NR.
- done  output  1  one-cycle pulse after round key NR is accepted.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, rk_valid=0, done=0, round_idx=0, round_key=0; rcon register=8'h01.
- States: IDLE, EMIT.
- IDLE, start=1: register key into round_key, round_idx=0, rcon=8'h01, go to EMIT. rk_valid=1 from the next cycle (latency 1). key is ignored when start=0.
- EMIT: rk_valid=1. round_key and round_idx are held stable while rk_ready=0.
- EMIT, rk_ready=1, round_idx<NR: in the same edge, round_key <= next_key, round_idx++, rcon <= xtime(rcon). rk_valid stays 1, giving back-to-back keys (11 keys in 11 cycles when rk_ready is held high).
- EMIT, rk_ready=1, round_idx==NR: go to IDLE; rk_valid=0 and done=1 in the following cycle only.
- next_key:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}, where RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0} and SubWord applies sbox to each byte.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- rcon: xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). Sequence 01,02,04,08,10,20,40,80,1b,36.
- start while busy: ignored; no restart.
- flush=1 (any state): next cycle state=IDLE, rk_valid=0, done=0, round_idx=0. flush has priority over rk_ready. start together with flush in IDLE: flush wins and start is dropped.
- start and done in the same cycle: start is accepted because the state is already IDLE.
- rst_n deasserted mid-expansion: outputs return immediately to reset values; no partial state survives.
- Critical path: 128-bit register, then sbox, then 4-deep XOR chain. Single cycle, no internal pipelining.

Optional Feature:
- Macro KEY_EXP_STORE_EN.
- Defined:
  - Adds a register file of 11 x 128 bits. Each key is written at its round_idx when accepted (rk_valid & rk_ready).
  - Adds ports rd_idx (input, IDX_W), rd_key (output, 128) and store_full (output, 1).
  - rd_key is registered, equal to entry[rd_idx] one cycle after rd_idx is sampled. rd_idx > NR returns 0.
  - store_full sets when key NR is written. It clears on reset, on flush and on an accepted start.
  - The file is not cleared by flush, only by rst_n.
  - Supports reverse-order (decryption) key reads without re-expansion.
- Undefined: no register file and none of these ports; area is the 128-bit key register plus control only.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx0 = key; idx1 = a0fafe1788542cb123a339392a6c7605; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done pulses exactly once, 12 cycles after start.
- Key all zeros -> idx1 = 62636363626363636263636362636363; idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Random rk_ready backpressure on the FIPS key -> round_key and round_idx stable while rk_valid & !rk_ready; same 11 keys in order; no skipped or duplicated index.
- Pulse start at idx 4 while busy -> ignored and sequence continues. Then flush at idx 6 -> rk_valid=0 and busy=0 next cycle. New start restarts at idx 0 with rcon 01.
- Drop rst_n at idx 7 -> all outputs 0 immediately. After release and start with the zero key, the idx1 value matches scenario 2.
- KEY_EXP_STORE_EN defined, FIPS key fully expanded -> store_full=1; rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later; rd_idx=12 gives 0.
